// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between the ALU writeback
// path and the LSU load-return path. Two valid/ready requesters are
// arbitrated combinationally. The winner is registered into a single output
// stage that drives the write port for one cycle per accepted transfer.
// Writes to x0 are accepted but never reach the write port. A saturating
// counter records every cycle in which both sources request together.
//
// Build option: define WB_ARB_FIXED_PRIO_EN to make the LSU always win under
// contention and to remove the round-robin pointer. By default (macro
// undefined) the arbiter alternates between the two sources.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              alu_valid_in,
    input  logic [ADDR_W-1:0] alu_rd_addr_in,
    input  logic [DATA_W-1:0] alu_rd_data_in,
    output logic              alu_ready_o,
    input  logic              lsu_valid_in,
    input  logic [ADDR_W-1:0] lsu_rd_addr_in,
    input  logic [DATA_W-1:0] lsu_rd_data_in,
    output logic              lsu_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [1:0]        grant_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_ALU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    logic              alu_win;
    logic              lsu_win;
    logic              contention;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        grant_q,   grant_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    assign contention = alu_valid_in && lsu_valid_in;

`ifdef WB_ARB_FIXED_PRIO_EN
    // Fixed priority: the LSU wins whenever it requests.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through it can leave a value unassigned and infer a latch.
        alu_win = 1'b0;
        lsu_win = 1'b0;
        lsu_win = lsu_valid_in;
        alu_win = alu_valid_in && !lsu_valid_in;
    end
`else
    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_LSU = 1'b1;

    logic prio_q, prio_d;

    // Round-robin: a lone requester wins, otherwise prio_q picks the winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through it can leave a value unassigned and infer a latch.
        alu_win = 1'b0;
        lsu_win = 1'b0;
        if (contention) begin
            if (prio_q == PRIO_ALU) begin
                alu_win = 1'b1;
            end else begin
                lsu_win = 1'b1;
            end
        end else begin
            alu_win = alu_valid_in;
            lsu_win = lsu_valid_in;
        end
    end

    // After a contended grant the loser gets priority; lone grants keep it.
    always_comb begin
        prio_d = prio_q;
        if (contention) begin
            prio_d = alu_win ? PRIO_LSU : PRIO_ALU;
        end
    end

    // Priority pointer register, ALU-first out of reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: sequential state is always written with non-blocking
            // assignments so every register samples pre-edge values.
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign alu_ready_o = alu_win;
    assign lsu_ready_o = lsu_win;
    assign xfer        = alu_win || lsu_win;
    assign sel_addr    = lsu_win ? lsu_rd_addr_in : alu_rd_addr_in;
    assign sel_data    = lsu_win ? lsu_rd_data_in : alu_rd_data_in;

    // Output stage next state: load a non-x0 winner; otherwise go idle and
    // keep the last address/data on the port.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        grant_d   = GRANT_NONE;
        if (xfer && (sel_addr != '0)) begin
            wr_en_d   = 1'b1;
            rd_addr_d = sel_addr;
            rd_data_d = sel_data;
            grant_d   = lsu_win ? GRANT_LSU : GRANT_ALU;
        end
    end

    // Contention counter next state, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (contention && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output stage and counter registers; reset drops any pending write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            grant_q   <= GRANT_NONE;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_data_o      = rd_data_q;
    assign grant_o        = grant_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter, instantiated
// with a 4-bit contention counter so saturation is reachable quickly.
// Expected values are hand-computed for both the round-robin build and the
// WB_ARB_FIXED_PRIO_EN build.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

`ifdef WB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk_in;
    logic              rst_n_in;
    logic              alu_valid_in;
    logic [ADDR_W-1:0] alu_rd_addr_in;
    logic [DATA_W-1:0] alu_rd_data_in;
    logic              alu_ready_o;
    logic              lsu_valid_in;
    logic [ADDR_W-1:0] lsu_rd_addr_in;
    logic [DATA_W-1:0] lsu_rd_data_in;
    logic              lsu_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [1:0]        grant_o;
    logic [CNT_W-1:0]  conflict_cnt_o;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .alu_valid_in  (alu_valid_in),
        .alu_rd_addr_in(alu_rd_addr_in),
        .alu_rd_data_in(alu_rd_data_in),
        .alu_ready_o   (alu_ready_o),
        .lsu_valid_in  (lsu_valid_in),
        .lsu_rd_addr_in(lsu_rd_addr_in),
        .lsu_rd_data_in(lsu_rd_data_in),
        .lsu_ready_o   (lsu_ready_o),
        .wr_en_o       (wr_en_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .grant_o       (grant_o),
        .conflict_cnt_o(conflict_cnt_o)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid_in   = v;
        alu_rd_addr_in = a;
        alu_rd_data_in = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        lsu_valid_in   = v;
        lsu_rd_addr_in = a;
        lsu_rd_data_in = d;
    endtask

    // Queued payloads for the held-valid scenario.
    logic [ADDR_W-1:0] alu_q_addr [2];
    logic [DATA_W-1:0] alu_q_data [2];
    logic [ADDR_W-1:0] lsu_q_addr [2];
    logic [DATA_W-1:0] lsu_q_data [2];
    logic [ADDR_W-1:0] got_addr [8];
    logic [DATA_W-1:0] got_data [8];
    logic [ADDR_W-1:0] exp_addr [4];
    logic [DATA_W-1:0] exp_data [4];

    initial begin
        int ai;
        int li;
        int nwr;
        int seven_cnt;
        logic a_acc;
        logic l_acc;

        rst_n_in = 1'b0;
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        repeat (2) @(posedge clk_in);
        #1;

        // ---- reset values ----
        check("rst_wr_en", 32'(wr_en_o), 32'h0);
        check("rst_addr", 32'(rd_addr_o), 32'h0);
        check("rst_data", rd_data_o, 32'h0);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_cnt", 32'(conflict_cnt_o), 32'h0);
        check("rst_readies", 32'({alu_ready_o, lsu_ready_o}), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // ---- ALU only: addr 5, 0xDEADBEEF ----
        @(negedge clk_in);
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("alu_only_ready", 32'({alu_ready_o, lsu_ready_o}), 32'h2);
        @(posedge clk_in);
        #1;
        drive_alu(1'b0, '0, '0);
        check("alu_only_wr_en", 32'(wr_en_o), 32'h1);
        check("alu_only_addr", 32'(rd_addr_o), 32'h5);
        check("alu_only_data", rd_data_o, 32'hDEADBEEF);
        check("alu_only_grant", 32'(grant_o), 32'h1);
        @(posedge clk_in);
        #1;
        check("alu_only_wr_drop", 32'(wr_en_o), 32'h0);
        check("alu_only_grant_idle", 32'(grant_o), 32'h0);

        // ---- both valid for 4 cycles: A,L,A,L (fixed: L,L,L,L) ----
        drive_alu(1'b1, 5'd1, 32'h11);
        drive_lsu(1'b1, 5'd2, 32'h22);
        for (int i = 0; i < 4; i++) begin
            logic alu_wins;
            alu_wins = !FIXED && (i % 2 == 0);
            @(negedge clk_in);
            check($sformatf("rr_alu_ready_%0d", i), 32'(alu_ready_o), 32'(alu_wins));
            check($sformatf("rr_lsu_ready_%0d", i), 32'(lsu_ready_o), 32'(!alu_wins));
            @(posedge clk_in);
            #1;
            if (i == 3) begin
                drive_alu(1'b0, '0, '0);
                drive_lsu(1'b0, '0, '0);
            end
            check($sformatf("rr_wr_en_%0d", i), 32'(wr_en_o), 32'h1);
            check($sformatf("rr_grant_%0d", i), 32'(grant_o), alu_wins ? 32'h1 : 32'h2);
            check($sformatf("rr_addr_%0d", i), 32'(rd_addr_o), alu_wins ? 32'h1 : 32'h2);
        end
        check("rr_cnt", 32'(conflict_cnt_o), 32'h4);

        // ---- LSU write to x0 ----
        drive_lsu(1'b1, 5'd0, 32'h1234);
        @(negedge clk_in);
        check("x0_ready", 32'({alu_ready_o, lsu_ready_o}), 32'h1);
        @(posedge clk_in);
        #1;
        drive_lsu(1'b0, '0, '0);
        check("x0_wr_en", 32'(wr_en_o), 32'h0);
        check("x0_grant", 32'(grant_o), 32'h0);
        check("x0_addr_hold", 32'(rd_addr_o), 32'h2);
        check("x0_data_hold", rd_data_o, 32'h22);

        // ---- held valid across a lost arbitration ----
        alu_q_addr[0] = 5'd6; alu_q_data[0] = 32'h66;
        alu_q_addr[1] = 5'd7; alu_q_data[1] = 32'h77;
        lsu_q_addr[0] = 5'd3; lsu_q_data[0] = 32'h33;
        lsu_q_addr[1] = 5'd4; lsu_q_data[1] = 32'h44;
        if (FIXED) begin
            exp_addr[0] = 5'd3; exp_data[0] = 32'h33;
            exp_addr[1] = 5'd4; exp_data[1] = 32'h44;
            exp_addr[2] = 5'd6; exp_data[2] = 32'h66;
            exp_addr[3] = 5'd7; exp_data[3] = 32'h77;
        end else begin
            exp_addr[0] = 5'd6; exp_data[0] = 32'h66;
            exp_addr[1] = 5'd3; exp_data[1] = 32'h33;
            exp_addr[2] = 5'd7; exp_data[2] = 32'h77;
            exp_addr[3] = 5'd4; exp_data[3] = 32'h44;
        end
        ai  = 0;
        li  = 0;
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            if (ai < 2) drive_alu(1'b1, alu_q_addr[ai], alu_q_data[ai]);
            else        drive_alu(1'b0, '0, '0);
            if (li < 2) drive_lsu(1'b1, lsu_q_addr[li], lsu_q_data[li]);
            else        drive_lsu(1'b0, '0, '0);
            @(negedge clk_in);
            a_acc = alu_ready_o;
            l_acc = lsu_ready_o;
            @(posedge clk_in);
            #1;
            if (a_acc) ai++;
            if (l_acc) li++;
            if (wr_en_o && nwr < 8) begin
                got_addr[nwr] = rd_addr_o;
                got_data[nwr] = rd_data_o;
                nwr++;
            end
        end
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        check("held_nwrites", 32'(nwr), 32'h4);
        seven_cnt = 0;
        for (int k = 0; k < nwr; k++) begin
            if (got_addr[k] == 5'd7) seven_cnt++;
        end
        check("held_alu_once", 32'(seven_cnt), 32'h1);
        for (int k = 0; k < 4 && k < nwr; k++) begin
            check($sformatf("held_addr_%0d", k), 32'(got_addr[k]), 32'(exp_addr[k]));
            check($sformatf("held_data_%0d", k), got_data[k], exp_data[k]);
        end
        check("held_cnt", 32'(conflict_cnt_o), FIXED ? 32'h6 : 32'h7);

        // ---- counter saturation: 20 contention cycles on x0 ----
        drive_alu(1'b1, 5'd0, 32'h0);
        drive_lsu(1'b1, 5'd0, 32'h0);
        repeat (8) @(posedge clk_in);
        #1;
        check("sat_cnt_8", 32'(conflict_cnt_o), FIXED ? 32'hE : 32'hF);
        repeat (12) @(posedge clk_in);
        #1;
        check("sat_cnt_20", 32'(conflict_cnt_o), 32'hF);
        check("sat_x0_no_write", 32'(wr_en_o), 32'h0);
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);

        // ---- asynchronous reset after an accepted transfer ----
        @(negedge clk_in);
        drive_alu(1'b1, 5'd9, 32'h99);
        @(posedge clk_in);
        #1;
        drive_alu(1'b0, '0, '0);
        check("prereset_wr_en", 32'(wr_en_o), 32'h1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_wr_en", 32'(wr_en_o), 32'h0);
        check("async_rst_addr", 32'(rd_addr_o), 32'h0);
        check("async_rst_data", rd_data_o, 32'h0);
        check("async_rst_grant", 32'(grant_o), 32'h0);
        check("async_rst_cnt", 32'(conflict_cnt_o), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("post_rst_no_write_0", 32'(wr_en_o), 32'h0);
        @(posedge clk_in);
        #1;
        check("post_rst_no_write_1", 32'(wr_en_o), 32'h0);

        // Priority returns to ALU-first after reset.
        drive_alu(1'b1, 5'd1, 32'h1);
        drive_lsu(1'b1, 5'd2, 32'h2);
        #1;
        check("post_rst_prio", 32'({alu_ready_o, lsu_ready_o}), FIXED ? 32'h1 : 32'h2);
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        @(posedge clk_in);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the register file's single write port between two writeback sources: the ALU result path and the load/store unit (LSU) load-return path. Arbitrates the two valid/ready requesters and registers the winning write into one output stage, which drives the register-file write port for exactly one cycle per accepted transfer. Writes to x0 are accepted and discarded, and the block counts contention cycles for performance monitoring.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- CNT_W, 16, width of the contention counter

- clk_in  input  1  clock; all state updates on the rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- alu_valid_in  input  1  ALU writeback request
- alu_rd_addr_in  input  ADDR_W  ALU destination register
- alu_rd_data_in  input  DATA_W  ALU result
- alu_ready_o  output  1  ALU request accepted this cycle
- lsu_valid_in  input  1  LSU writeback request
- lsu_rd_addr_in  input  ADDR_W  LSU destination register
- lsu_rd_data_in  input  DATA_W  load data
- lsu_ready_o  output  1  LSU request accepted this cycle
- wr_en_o  output  1  register-file write enable
- rd_addr_o  output  ADDR_W  register-file write address
- rd_data_o  output  DATA_W  register-file write data
- grant_o  output  2  one-hot source of the current output write: bit0 = ALU, bit1 = LSU; 00 when idle
- conflict_cnt_o  output  CNT_W  saturating count of cycles with both valids high

## Operation
- A transfer occurs on a rising edge where valid and ready are both high.
- Requesters hold valid, address and data stable until they see ready. They must not make valid depend on ready.
- The ready outputs are combinational from the valids and the priority state. At most one ready is high per cycle, and ready is never high without its own valid.
- Only one requester valid: that requester is granted.
- Both valid: round-robin. The priority pointer prio_q selects the winner, and after each contended grant prio_q points to the loser.
- An uncontended grant leaves prio_q unchanged.
- prio_q resets to ALU-first.
- The output stage drains every cycle, so the register file applies no backpressure and ready never depends on output state.
- Accepted transfer with address 0:
  - The handshake completes normally.
  - Next cycle: wr_en_o = 0, grant_o = 00, and rd_addr_o / rd_data_o hold their previous values.
- conflict_cnt_o increments on every cycle with alu_valid_in && lsu_valid_in and saturates at all-ones (no wrap).

## Timing
- Latency is 1 cycle: a transfer at edge N makes wr_en_o / rd_addr_o / rd_data_o / grant_o valid during the cycle after edge N and updates them at edge N+1.
- wr_en_o is high for exactly one cycle per non-x0 transfer.
- Sustained throughput is one write per cycle. Under continuous contention the two sources alternate: A, L, A, L, ...
- Reset values:
  - wr_en_o = 0, rd_addr_o = 0, rd_data_o = 0, grant_o = 00, conflict_cnt_o = 0
  - prio_q = ALU-first
  - ready outputs follow the combinational rule, so they are 0 while both valids are low
- Reset mid-operation: an accepted-but-not-yet-written transfer is dropped. The requester treats it as completed.
- A valid that rises in the same cycle another is being granted competes only from the next edge onward. The arbitration decision uses current-cycle valids only.

## Configuration
- WB_ARB_FIXED_PRIO_EN defined:
  - LSU always wins under contention.
  - prio_q is removed.
  - ALU is granted only when lsu_valid_in = 0.
- WB_ARB_FIXED_PRIO_EN undefined: round-robin as above (default).
- conflict_cnt_o and all other behaviour are identical in both builds.

## Test plan
- Reset, then ALU only (addr 5, data 0xDEADBEEF) -> alu_ready_o = 1 at the same edge; next cycle wr_en_o = 1, rd_addr_o = 5, rd_data_o = 0xDEADBEEF, grant_o = 01; the following cycle wr_en_o = 0.
- Both valid for 4 cycles (ALU addr 1, LSU addr 2) -> grants A, L, A, L; rd_addr_o sequence 1, 2, 1, 2; conflict_cnt_o = 4. With WB_ARB_FIXED_PRIO_EN defined: L, L, L, L and alu_ready_o stays 0.
- LSU write to addr 0, data 0x1234 -> lsu_ready_o = 1; next cycle wr_en_o = 0, grant_o = 00, rd_addr_o unchanged.
- ALU valid held while it loses contention -> payload stable until alu_ready_o; written exactly once, never duplicated or lost.
- Force conflict_cnt_o to near-max with CNT_W = 4 and 20 contention cycles -> saturates at 0xF.
- Assert rst_n_in low mid-cycle after an accepted transfer -> outputs go to reset values immediately (asynchronously); no write appears after release.
